// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the arbitro_rr word arbiter.
//   estado_e      : encodings driven on the estado port
//   BurstCntW     : width of the round-robin burst counter (BURST up to 15)
//   dest_width()  : width of the destination field for an N-way arbiter
// Optional feature macro: ARBITRO_CNT_EN (see arbitro_rr.sv).
package arbitro_rr_pkg;

  typedef enum logic [1:0] {
    StInit   = 2'b00,
    StIdle   = 2'b01,
    StActive = 2'b10,
    StStall  = 2'b11
  } estado_e;

  localparam int unsigned BurstCntW = 4;

  // Destination field width; at least one bit so ports never collapse.
  function automatic int unsigned dest_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arbitro_rr_grant.sv
// Rotating first-one picker.
//   i_elig  : N-bit eligible vector
//   i_ptr   : search start index (tie to 0 for fixed priority)
//   o_grant : one-hot of first eligible bit at or after i_ptr, zero if none
//   o_valid : some bit granted
//   o_idx   : binary index of the granted bit
module arbitro_rr_grant
  import arbitro_rr_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]             i_elig,
  input  logic [dest_width(N)-1:0] i_ptr,
  output logic [N-1:0]             o_grant,
  output logic                     o_valid,
  output logic [dest_width(N)-1:0] o_idx
);

  localparam int unsigned PW = dest_width(N);

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    // N is a power of two, so the index wraps by plain truncation.
    for (int unsigned k = 0; k < N; k++) begin
      if (!o_valid && i_elig[i_ptr + PW'(k)]) begin
        o_valid                 = 1'b1;
        o_idx                   = i_ptr + PW'(k);
        o_grant[i_ptr + PW'(k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// N-input / N-output word arbiter between an input FIFO bank and an output FIFO bank.
// Each cycle one non-empty input whose head word's destination is not almost-full is
// popped (combinationally) and its word pushed to the destination on the next edge.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low
//   fifo_out    : show-ahead head words, input i at [i*W +: W]
//   empty       : input FIFO empty flags
//   almost_full : output FIFO almost-full flags
//   pop         : one-hot/zero pop of granted input (combinational)
//   push        : one-hot/zero push into destination FIFO (registered)
//   data_out    : registered word accompanying push
//   estado      : registered state 00 INIT, 01 IDLE, 10 ACTIVE, 11 STALL
//   cnt_out     : (only with ARBITRO_CNT_EN) per-destination saturating push counters
// Optional feature macro: ARBITRO_CNT_EN.
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 12,
  parameter int unsigned MODE  = 1,
  parameter int unsigned BURST = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] fifo_out,
  input  logic [N-1:0]   empty,
  input  logic [N-1:0]   almost_full,
  output logic [N-1:0]   pop,
  output logic [N-1:0]   push,
  output logic [W-1:0]   data_out,
`ifdef ARBITRO_CNT_EN
  output logic [N*8-1:0] cnt_out,
`endif
  output logic [1:0]     estado
);

  localparam int unsigned DW = dest_width(N);

  estado_e              r_estado, w_estado_d;
  logic [DW-1:0]        r_ptr, w_ptr_d, w_ptr;
  logic [BurstCntW-1:0] r_cnt, w_cnt_d;
  logic [N-1:0]         r_push, w_push_d;
  logic [W-1:0]         r_data, w_data_d;

  logic [DW-1:0] w_dest [N];
  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_gnt;
  logic          w_gv;
  logic [DW-1:0] w_gidx;
  logic          w_fire;
  logic [W-1:0]  w_head;
  logic [DW-1:0] w_hdest;

  // Destination of each head word and eligibility.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_dest[i] = fifo_out[i*W + W - 1 -: DW];
      w_elig[i] = !empty[i] && !almost_full[w_dest[i]];
    end
  end

  assign w_ptr = (MODE == 0) ? '0 : r_ptr;

  arbitro_rr_grant #(
    .N (N)
  ) u_grant (
    .i_elig  (w_elig),
    .i_ptr   (w_ptr),
    .o_grant (w_gnt),
    .o_valid (w_gv),
    .o_idx   (w_gidx)
  );

  // No grants in INIT; during reset r_estado is INIT, which also forces pop low.
  assign w_fire = (r_estado != StInit) && w_gv;
  assign pop    = w_fire ? w_gnt : '0;

  // One-hot mux of the granted head word and its destination.
  always_comb begin
    w_head  = '0;
    w_hdest = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_head  = fifo_out[i*W +: W];
        w_hdest = w_dest[i];
      end
    end
  end

  // State and output-register next values.
  always_comb begin
    w_estado_d = r_estado;
    w_push_d   = '0;
    w_data_d   = r_data;
    if (r_estado == StInit) begin
      w_estado_d = StIdle;
    end else if (w_fire) begin
      w_estado_d = StActive;
    end else if (~&empty) begin
      w_estado_d = StStall;
    end else begin
      w_estado_d = StIdle;
    end
    if (w_fire) begin
      w_push_d[w_hdest] = 1'b1;
      w_data_d          = w_head;
    end
  end

  // Burst bookkeeping: stay on the granted input until its quantum is used, then move past it.
  // A grant away from the pointer (pointer input went ineligible) always restarts the burst.
  always_comb begin
    w_ptr_d = r_ptr;
    w_cnt_d = r_cnt;
    if (w_fire) begin
      if ((w_gidx == r_ptr) && (r_cnt < BurstCntW'(BURST - 1))) begin
        w_cnt_d = r_cnt + BurstCntW'(1);
      end else begin
        w_ptr_d = w_gidx + DW'(1);
        w_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado <= StInit;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_push   <= '0;
      r_data   <= '0;
    end else begin
      r_estado <= w_estado_d;
      r_ptr    <= w_ptr_d;
      r_cnt    <= w_cnt_d;
      r_push   <= w_push_d;
      r_data   <= w_data_d;
    end
  end

  assign push     = r_push;
  assign data_out = r_data;
  assign estado   = r_estado;

`ifdef ARBITRO_CNT_EN
  logic [7:0] r_pcnt [N];

  // Counted on the edge that issues the push, so cnt_out lines up with push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) r_pcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_push_d[i] && (r_pcnt[i] != 8'hFF)) r_pcnt[i] <= r_pcnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < N; i++) cnt_out[i*8 +: 8] = r_pcnt[i];
  end
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// Scoreboard bench for arbitro_rr (N=4, W=12, MODE=1, BURST=2; dest = bits[11:10]).
module tb_arbitro_rr;

  localparam int unsigned N = 4;
  localparam int unsigned W = 12;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] fifo_out;
  logic [N-1:0]   empty;
  logic [N-1:0]   almost_full;
  logic [N-1:0]   pop;
  logic [N-1:0]   push;
  logic [W-1:0]   data_out;
  logic [1:0]     estado;
`ifdef ARBITRO_CNT_EN
  logic [N*8-1:0] cnt_out;
`endif

  always #5 clk = ~clk;

  arbitro_rr #(
    .N     (4),
    .W     (12),
    .MODE  (1),
    .BURST (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_out    (fifo_out),
    .empty       (empty),
    .almost_full (almost_full),
    .pop         (pop),
    .push        (push),
    .data_out    (data_out),
`ifdef ARBITRO_CNT_EN
    .cnt_out     (cnt_out),
`endif
    .estado      (estado)
  );

  // Input FIFO models and scoreboard queues.
  logic [W-1:0]  q [N][$];
  logic [15:0]   exp_q [$];
  string         rq_n [$];
  logic [31:0]   rq_g [$];
  logic [31:0]   rq_e [$];
  int            n_cmp = 0;
  int            n_bad = 0;

  // Monitor: the only process that counts comparisons.
  always @(negedge clk) begin
    while (rq_n.size() > 0) begin
      string       nm;
      logic [31:0] g, e;
      nm = rq_n.pop_front();
      g  = rq_g.pop_front();
      e  = rq_e.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got %0h want %0h", nm, g, e);
      end
    end
    if (push !== '0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL push_unexpected: got push=%b data=%h want no push", push, data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({push, data_out} !== e) begin
          n_bad++;
          $display("FAIL push: got push=%b data=%h want push=%b data=%h",
                   push, data_out, e[15:12], e[11:0]);
        end
      end
    end
  end

  task automatic req(input string nm, input logic [31:0] g, input logic [31:0] e);
    rq_n.push_back(nm);
    rq_g.push_back(g);
    rq_e.push_back(e);
  endtask

  task automatic expect_push(input logic [3:0] pu, input logic [11:0] d);
    exp_q.push_back({pu, d});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      empty[i] = (q[i].size() == 0);
      fifo_out[i*W +: W] = empty[i] ? '0 : q[i][0];
    end
  endtask

  // One clock: sample pop mid-cycle, then commit the pop to the FIFO model after the edge.
  task automatic tick(output logic [N-1:0] p);
    @(negedge clk);
    p = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (p[i] && q[i].size() > 0) void'(q[i].pop_front());
    end
    drive();
  endtask

  int gorder [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};

  initial begin
    logic [N-1:0] p;
    int           kk [N];
    reset       = 1'b0;
    almost_full = '0;
    drive();

    // Reset and INIT/IDLE sequence.
    repeat (2) @(posedge clk);
    #1;
    req("rst_estado", 32'(estado), 32'd0);
    req("rst_pop", 32'(pop), 32'd0);
    req("rst_push", 32'(push), 32'd0);
    req("rst_data", 32'(data_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    req("init_estado", 32'(estado), 32'd0);
    @(posedge clk);
    #1;
    req("idle_estado", 32'(estado), 32'd1);

    // Single word on input 0.
    q[0].push_back(12'b000010010110);
    expect_push(4'b0001, 12'h096);
    drive();
    tick(p);
    req("single_pop", 32'(p), 32'd1);
    req("single_estado", 32'(estado), 32'd2);
    tick(p);
    req("single_pop_after", 32'(p), 32'd0);
    req("single_idle", 32'(estado), 32'd1);

    // Reset while a push is in flight: push must clear immediately.
    q[1].push_back(12'h455);
    drive();
    tick(p);
    req("mid_pop", 32'(p), 32'd2);
    reset = 1'b0;
    #1;
    req("mid_push_clear", 32'(push), 32'd0);

    // Preload all inputs during reset; INIT must not grant.
    for (int i = 0; i < N; i++) begin
      kk[i] = 0;
      for (int k = 0; k < 4; k++) q[i].push_back({2'(i), 10'(i * 16 + k)});
    end
    for (int s = 0; s < 16; s++) begin
      int i;
      i = gorder[s];
      expect_push(4'(1 << i), {2'(i), 10'(i * 16 + kk[i])});
      kk[i]++;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    req("init_no_grant", 32'(pop), 32'd0);
    req("init_estado2", 32'(estado), 32'd0);
    for (int s = 0; s < 16; s++) begin
      tick(p);
      req($sformatf("rr_pop%0d", s), 32'(p), 32'(1 << gorder[s]));
    end

    // Stall on almost-full destination, then release.
    q[1].push_back(12'b100011110000);
    almost_full = 4'b0100;
    drive();
    tick(p);
    req("stall_pop", 32'(p), 32'd0);
    req("stall_estado", 32'(estado), 32'd3);
    almost_full = 4'b0000;
    expect_push(4'b0100, 12'h8F0);
    tick(p);
    req("unstall_pop", 32'(p), 32'd2);
    req("unstall_estado", 32'(estado), 32'd2);

    // almost_full rises the cycle after a pop: that push still happens, nothing further.
    q[0].push_back(12'h812);
    q[0].push_back(12'h834);
    expect_push(4'b0100, 12'h812);
    drive();
    tick(p);
    req("af_pop", 32'(p), 32'd1);
    almost_full = 4'b0100;
    tick(p);
    req("af_hold_pop", 32'(p), 32'd0);
    req("af_hold_estado", 32'(estado), 32'd3);
    tick(p);
    req("af_hold_pop2", 32'(p), 32'd0);
    almost_full = 4'b0000;
    expect_push(4'b0100, 12'h834);
    tick(p);
    req("af_release_pop", 32'(p), 32'd1);

    // Blocked input 0 (dest 3) does not stop eligible input 1.
    q[0].push_back(12'hC01);
    q[1].push_back(12'h402);
    almost_full = 4'b1000;
    expect_push(4'b0010, 12'h402);
    expect_push(4'b1000, 12'hC01);
    drive();
    tick(p);
    req("bypass_pop", 32'(p), 32'd2);
    tick(p);
    req("blocked_pop", 32'(p), 32'd0);
    req("blocked_estado", 32'(estado), 32'd3);
    almost_full = 4'b0000;
    tick(p);
    req("unblocked_pop", 32'(p), 32'd1);

`ifdef ARBITRO_CNT_EN
    for (int k = 0; k < 300; k++) begin
      q[0].push_back({2'b11, 10'(k)});
      expect_push(4'b1000, {2'b11, 10'(k)});
    end
    drive();
    repeat (302) tick(p);
    req("cnt_sat", 32'(cnt_out[31:24]), 32'd255);
    reset = 1'b0;
    #1;
    req("cnt_reset", 32'(cnt_out[31:24]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
`endif

    repeat (3) tick(p);
    req("exp_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
